// File: rtl/divider_sequential_if.sv
// Operand/result bundle for the sequential restoring divider.
// The master drives the request and operands; the slave returns status and results.
interface divider_sequential_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         divide_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, divide_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, divide_by_zero
  );
endinterface

// File: rtl/divider_sequential.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Results are held from the done pulse until the next accepted start.
module divider_sequential #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic                clock,
  input  logic                reset,
  divider_sequential_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [N-1:0]  dividend_r;
  logic [M-1:0]  divisor_r;
  logic [M:0]    partial_r;
  logic [N-1:0]  quot_acc_r;
  logic [CW-1:0] count_r;
  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  quotient_r;
  logic [M-1:0]  remainder_r;
  logic          dbz_r;

  logic [M:0]    shifted_s;
  logic [M:0]    partial_next_s;
  logic          q_bit_s;

  // One restoring step: bring in the next dividend bit and trial-subtract.
  always_comb begin
    shifted_s      = {partial_r[M-1:0], dividend_r[N-1]};
    partial_next_s = shifted_s;
    q_bit_s        = 1'b0;
    if (shifted_s >= {1'b0, divisor_r}) begin
      partial_next_s = shifted_s - {1'b0, divisor_r};
      q_bit_s        = 1'b1;
    end else begin
      partial_next_s = shifted_s;
      q_bit_s        = 1'b0;
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      dividend_r  <= {N{1'b0}};
      divisor_r   <= {M{1'b0}};
      partial_r   <= {(M+1){1'b0}};
      quot_acc_r  <= {N{1'b0}};
      count_r     <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {N{1'b0}};
      remainder_r <= {M{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (bus.start) begin
            if (bus.divisor != {M{1'b0}}) begin
              dividend_r <= bus.dividend;
              divisor_r  <= bus.divisor;
              partial_r  <= {(M+1){1'b0}};
              quot_acc_r <= {N{1'b0}};
              count_r    <= CW'(N - 1);
              quotient_r <= {N{1'b0}};
              dbz_r      <= 1'b0;
              busy_r     <= 1'b1;
              state_r    <= RUN;
            end else begin
              // Divide by zero finishes immediately with a saturated quotient.
              quotient_r  <= {N{1'b1}};
              remainder_r <= {M{1'b0}};
              dbz_r       <= 1'b1;
              done_r      <= 1'b1;
              state_r     <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          partial_r  <= partial_next_s;
          quot_acc_r <= {quot_acc_r[N-2:0], q_bit_s};
          dividend_r <= {dividend_r[N-2:0], 1'b0};
          if (count_r == {CW{1'b0}}) begin
            quotient_r  <= {quot_acc_r[N-2:0], q_bit_s};
            remainder_r <= partial_next_s[M-1:0];
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else begin
            count_r <= count_r - CW'(1);
            busy_r  <= 1'b1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.quotient       = quotient_r;
  assign bus.remainder      = remainder_r;
  assign bus.divide_by_zero = dbz_r;
endmodule

// File: tb/tb_divider_sequential.sv
// Directed and exhaustive checks of divider_sequential against a scoreboard
// filled with reference results as each operation is started.
module tb_divider_sequential;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;
  exp_t sb[$];

  divider_sequential_if #(.N(8), .M(4)) bus ();
  divider_sequential #(.N(8), .M(4)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_div(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = 4'd0; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = 4'(a % b); e.z = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: each done pulse pops the oldest expected result.
  always @(negedge clock) begin
    if (bus.done) begin
      exp_t e;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("quotient", 32'(bus.quotient), 32'(e.q));
        check("remainder", 32'(bus.remainder), 32'(e.r));
        check("dbz", 32'(bus.divide_by_zero), 32'(e.z));
      end
    end
  end

  // Start one operation, then wait (bounded) for done; optionally check timing.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit chk_lat);
    int cyc;
    int busy_cyc;
    sb.push_back(ref_div(a, b));
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    cyc = 0;
    busy_cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (bus.busy) busy_cyc++;
    end while (!bus.done && cyc < 30);
    check("done_seen", 32'(bus.done), 32'd1);
    if (chk_lat) begin
      check("latency", 32'(cyc), (b == 4'd0) ? 32'd1 : 32'd9);
      check("busy_cycles", 32'(busy_cyc), (b == 4'd0) ? 32'd0 : 32'd8);
    end
    @(negedge clock);
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cyc;
    int dones;
    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 4'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_q", 32'(bus.quotient), 32'd0);
    check("rst_r", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.divide_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(8'd200, 4'd7, 1'b1);
    check("held_q_200_7", 32'(bus.quotient), 32'h1C);
    check("held_r_200_7", 32'(bus.remainder), 32'd4);
    run_op(8'd255, 4'd15, 1'b1);
    check("held_q_255_15", 32'(bus.quotient), 32'd17);
    run_op(8'd0, 4'd1, 1'b1);
    run_op(8'd255, 4'd1, 1'b1);
    check("held_q_255_1", 32'(bus.quotient), 32'd255);
    run_op(8'd5, 4'd9, 1'b1);
    check("held_r_5_9", 32'(bus.remainder), 32'd5);
    run_op(8'd13, 4'd0, 1'b1);
    check("held_q_13_0", 32'(bus.quotient), 32'hFF);
    check("held_dbz_13_0", 32'(bus.divide_by_zero), 32'd1);

    // Start ignored while busy; operand inputs scrambled mid-run.
    sb.push_back(ref_div(8'd100, 4'd3));
    bus.dividend = 8'd100; bus.divisor = 4'd3; bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clock);
    bus.dividend = 8'd50; bus.divisor = 4'd5; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; bus.dividend = 8'd77; bus.divisor = 4'd2;
    cyc = 0;
    while (!bus.done && cyc < 30) begin @(negedge clock); cyc++; end
    check("ignored_done", 32'(bus.done), 32'd1);
    check("ignored_q", 32'(bus.quotient), 32'd33);
    check("ignored_r", 32'(bus.remainder), 32'd1);
    repeat (2) @(negedge clock);
    check("ignored_idle", 32'(bus.busy), 32'd0);

    // Reset mid-run aborts with no done pulse.
    bus.dividend = 8'd200; bus.divisor = 4'd7; bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_q", 32'(bus.quotient), 32'd0);
    check("abort_r", 32'(bus.remainder), 32'd0);
    check("abort_dbz", 32'(bus.divide_by_zero), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin @(negedge clock); if (bus.done) dones++; end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op(8'd9, 4'd2, 1'b1);
    check("after_abort_q", 32'(bus.quotient), 32'd4);

    // start held high: back-to-back operations N+2 cycles apart.
    sb.push_back(ref_div(8'd60, 4'd4));
    sb.push_back(ref_div(8'd61, 4'd4));
    bus.dividend = 8'd60; bus.divisor = 4'd4; bus.start = 1'b1;
    @(posedge clock);
    #1 bus.dividend = 8'd61;
    cyc = 0;
    while (!bus.done && cyc < 30) begin @(negedge clock); cyc++; end
    check("b2b_first_done", 32'(bus.done), 32'd1);
    check("b2b_first_q", 32'(bus.quotient), 32'd15);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (cyc == 2) bus.start = 1'b0;
    end while (!bus.done && cyc < 30);
    check("b2b_spacing", 32'(cyc), 32'd10);
    check("b2b_second_r", 32'(bus.remainder), 32'd1);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);

    // Exhaustive sweep over all operand pairs.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), 1'b0);
      end
    end

    repeat (3) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
